clock_div_prog: RTL

Parametrised, runtime-programmable successor to the fixed clock divider. It generates a divided clock-level output, a one-cycle period-start strobe and the live phase counter. The divisor changes through a load handshake and takes effect only at a period boundary, so downstream pixel/timing logic never sees a runt period. It sits in the clock-enable path feeding the display timing and raster blocks.

---
 rtl/clock_div_prog_pkg.sv | 16 +
 rtl/clock_div_prog_load.sv | 69 ++++++
 rtl/clock_div_prog.sv | 137 +++++++++++++
 3 files changed

// File: rtl/clock_div_prog_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clock_div_prog_pkg;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [31:0] DIV_MIN = 32'd2;

    // High-phase length of a period; evaluated at 32 bits so div=2**CNT_W-1 cannot overflow.
    function automatic logic [31:0] half_high(input logic [31:0] div);
        return (div + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clock_div_prog_load.sv
// Divisor load handshake: validates and holds a pending divisor until the core applies it.
module clock_div_prog_load
    import clock_div_prog_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic             apply_evt,
    output logic             apply_div,
    output logic [CNT_W-1:0] div_new,
    output logic             load_ack,
    output logic             busy,
    output logic             err
);

    logic [CNT_W-1:0] pend_r;
    logic             busy_r;
    logic             ack_r;
    logic             err_r;
    logic             err_s;
    logic             capture_s;
    logic             busy_nxt_s;

    // Request classification; a too-small divisor is rejected even while busy.
    always_comb begin
        err_s      = 1'b0;
        capture_s  = 1'b0;
        busy_nxt_s = busy_r;
        if (load_i && (32'(div_i) < DIV_MIN)) begin
            err_s = 1'b1;
        end else if (load_i && !busy_r) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
        if (capture_s) begin
            busy_nxt_s = 1'b1;
        end else if (busy_r && apply_evt) begin
            busy_nxt_s = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end
    end

    // Pending divisor and handshake flags.
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            pend_r <= {CNT_W{1'b0}};
            busy_r <= 1'b0;
            ack_r  <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            pend_r <= capture_s ? div_i : pend_r;
            busy_r <= busy_nxt_s;
            ack_r  <= capture_s;
            err_r  <= err_s;
        end
    end

    assign apply_div = busy_r && apply_evt;
    assign div_new   = pend_r;
    assign load_ack  = ack_r;
    assign busy      = busy_r;
    assign err       = err_r;

endmodule

// File: rtl/clock_div_prog.sv
// Runtime-programmable clock divider with period-boundary divisor updates.
// Optional CLK_DIV_PROG_SYNC_EN adds sync_i to restart the phase while running.
module clock_div_prog
    import clock_div_prog_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DIV_DEFAULT = 4
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] div_i,
`ifdef CLK_DIV_PROG_SYNC_EN
    input  logic             sync_i,
`endif
    output logic             load_ack_o,
    output logic             busy_o,
    output logic             err_o,
    output logic             clk_o,
    output logic             tick_o,
    output logic [CNT_W-1:0] counter_o
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] div_r;
    logic [CNT_W-1:0] counter_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] div_new_s;
    logic             clk_r;
    logic             tick_r;
    logic             clk_nxt_s;
    logic             tick_nxt_s;
    logic             apply_evt_s;
    logic             apply_div_s;
    logic             sync_s;

`ifdef CLK_DIV_PROG_SYNC_EN
    assign sync_s = sync_i;
`else
    assign sync_s = 1'b0;
`endif

    clock_div_prog_load #(
        .CNT_W(CNT_W)
    ) u_load (
        .clk_i     (clk_i),
        .reset     (reset),
        .load_i    (load_i),
        .div_i     (div_i),
        .apply_evt (apply_evt_s),
        .apply_div (apply_div_s),
        .div_new   (div_new_s),
        .load_ack  (load_ack_o),
        .busy      (busy_o),
        .err       (err_o)
    );

    // State register.
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            state_r <= STOP;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: en_i alone selects RUN or STOP.
    always_comb begin
        state_nxt_s = STOP;
        case (state_r)
            STOP:    state_nxt_s = en_i ? RUN : STOP;
            RUN:     state_nxt_s = en_i ? RUN : STOP;
            default: state_nxt_s = STOP;
        endcase
    end

    // Next phase, clock level, strobe, and the edges where a pending divisor may be applied.
    always_comb begin
        cnt_inc_s   = (counter_r == (div_r - CNT_W'(1))) ? {CNT_W{1'b0}} : (counter_r + CNT_W'(1));
        cnt_nxt_s   = {CNT_W{1'b0}};
        clk_nxt_s   = 1'b0;
        tick_nxt_s  = 1'b0;
        apply_evt_s = 1'b0;
        case (state_r)
            STOP: begin
                apply_evt_s = 1'b1;
                if (en_i) begin
                    clk_nxt_s  = 1'b1;
                    tick_nxt_s = 1'b1;
                end else begin
                    clk_nxt_s  = 1'b0;
                    tick_nxt_s = 1'b0;
                end
            end
            RUN: begin
                if (!en_i) begin
                    apply_evt_s = 1'b1;
                end else if (sync_s) begin
                    apply_evt_s = 1'b1;
                    clk_nxt_s   = 1'b1;
                    tick_nxt_s  = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_inc_s;
                    clk_nxt_s   = 32'(cnt_inc_s) < half_high(32'(div_r));
                    tick_nxt_s  = (cnt_inc_s == {CNT_W{1'b0}});
                    apply_evt_s = tick_nxt_s;
                end
            end
            default: begin
                apply_evt_s = 1'b0;
            end
        endcase
    end

    // Registered phase outputs and active divisor.
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            counter_r <= {CNT_W{1'b0}};
            clk_r     <= 1'b0;
            tick_r    <= 1'b0;
            div_r     <= CNT_W'(DIV_DEFAULT);
        end else begin
            counter_r <= cnt_nxt_s;
            clk_r     <= clk_nxt_s;
            tick_r    <= tick_nxt_s;
            div_r     <= apply_div_s ? div_new_s : div_r;
        end
    end

    assign counter_o = counter_r;
    assign clk_o     = clk_r;
    assign tick_o    = tick_r;

endmodule
